// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle between NREQ requesters and the shared register arbiter.
// Requesters drive req/wdata/lock; the arbiter drives gnt/ack/q/busy and exposes its FSM state on state_dbg.
interface shared_reg_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    // Handshake: req[i] is a level request held until ack[i]; gnt[i] marks the owner,
    // and the write lands (q updated, ack[i] pulsed) on the edge after gnt while req[i] is still high.
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       lock;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  busy;
    logic [1:0]            state_dbg;

    modport master (
        output req, wdata, lock,
        input  gnt, ack, q, busy, state_dbg
    );

    modport slave (
        input  req, wdata, lock,
        output gnt, ack, q, busy, state_dbg
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Define SHARED_REG_ARB_LOCK_EN to add the HOLD state (locked back-to-back writes).
module shared_reg_arbiter #(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                 clk,
    input logic                 reset,
    shared_reg_arbiter_if.slave bus
);
    localparam int IW  = $clog2(NREQ);
    localparam int IW1 = IW + 1;
    localparam logic [IW:0] NREQ_W = IW1'(NREQ);

`ifdef SHARED_REG_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [NREQ-1:0]  gnt_r;
    logic [NREQ-1:0]  ack_r;
    logic [WIDTH-1:0] q_r;

    logic [NREQ-1:0]  req_rot;
    logic             win_found;
    logic [IW:0]      win_off;
    logic [IW:0]      win_sum;
    logic [IW:0]      nxt_sum;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    next_ptr;

    // Rotate requests so bit 0 is the requester at ptr; the first set bit is the winner.
    always_comb begin
        req_rot   = NREQ'({bus.req, bus.req} >> ptr);
        win_found = 1'b0;
        win_off   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                win_off   = IW1'(k);
            end
        end
        win_sum  = {1'b0, ptr} + win_off;
        win_idx  = (win_sum >= NREQ_W) ? IW'(win_sum - NREQ_W) : IW'(win_sum);
        nxt_sum  = {1'b0, win_idx} + IW1'(1);
        next_ptr = (nxt_sum >= NREQ_W) ? '0 : IW'(nxt_sum);
    end

    logic             sel_req;
    logic [WIDTH-1:0] sel_data;

    always_comb begin
        sel_req  = |(bus.req & gnt_r);
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_r[i]) sel_data = sel_data | bus.wdata[i*WIDTH +: WIDTH];
        end
    end

`ifdef SHARED_REG_ARB_LOCK_EN
    logic sel_lock;
    assign sel_lock = |(bus.lock & gnt_r);
`else
    logic lock_unused;
    assign lock_unused = ^bus.lock;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            gnt_r <= '0;
            ack_r <= '0;
            q_r   <= RESET_VAL;
        end else begin
            ack_r <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt_r <= NREQ'(1) << win_idx;
                        ptr   <= next_ptr;
                        state <= GRANT;
                    end
                end
`ifdef SHARED_REG_ARB_LOCK_EN
                GRANT, HOLD: begin
`else
                GRANT: begin
`endif
                    // wdata is taken at this edge, not at the grant edge; a withdrawn request writes nothing.
                    if (sel_req) begin
                        q_r   <= sel_data;
                        ack_r <= gnt_r;
                    end
`ifdef SHARED_REG_ARB_LOCK_EN
                    if (sel_req && sel_lock) begin
                        state <= HOLD;
                    end else begin
                        gnt_r <= '0;
                        state <= IDLE;
                    end
`else
                    gnt_r <= '0;
                    state <= IDLE;
`endif
                end
                default: begin
                    gnt_r <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.ack       = ack_r;
    assign bus.q         = q_r;
    assign bus.busy      = (state != IDLE);
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: vector table, hand-written corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_shared_reg_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
`ifdef SHARED_REG_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    shared_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    shared_reg_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [7:0]  q;
        logic        busy;
    } vec_t;
    vec_t vecs[14];

    // Reference model: who holds the grant (-1 = nobody), rotation pointer, register value.
    int         m_ptr;
    int         m_g;
    logic [7:0] m_q;
    logic [3:0] m_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] wd);
        @(negedge clk);
        bus.req   = r;
        bus.lock  = l;
        bus.wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] a,
                              input logic [7:0] qv, input logic b);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
        check({tag, "_ack"}, 32'(bus.ack), 32'(a));
        check({tag, "_q"}, 32'(bus.q), 32'(qv));
        check({tag, "_busy"}, 32'(bus.busy), 32'(b));
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_g   = -1;
        m_q   = 8'h00;
        m_ack = 4'h0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        logic [3:0]  r;
        logic [3:0]  l;
        logic [31:0] wd;
        int          w;
        r  = bus.req;
        l  = bus.lock;
        wd = bus.wdata;
        if (m_g < 0) begin
            m_ack = 4'h0;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (w >= 0) begin
                m_g   = w;
                m_ptr = (w + 1) % NREQ;
            end
        end else begin
            if (r[m_g]) begin
                m_q   = wd[m_g*8 +: 8];
                m_ack = 4'(1 << m_g);
                exp_q.push_back(m_q);
            end else begin
                m_ack = 4'h0;
            end
            if (!(LOCK_ON && l[m_g] && r[m_g])) m_g = -1;
        end
    endtask

    task automatic model_compare();
        logic [3:0] eg;
        eg = (m_g < 0) ? 4'h0 : 4'(1 << m_g);
        check_outs("rnd", eg, m_ack, m_q, (m_g >= 0));
        if (bus.ack != 4'h0) begin
            if (exp_q.size() > 0) check("sb_q", 32'(bus.q), 32'(exp_q.pop_front()));
            else check("sb_pending", 32'(exp_q.size()), 32'd1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bus.req   = 4'h0;
        bus.lock  = 4'h0;
        bus.wdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    logic [3:0]  lk_req[5];
    logic [3:0]  lk_lock[5];
    logic [31:0] lk_wd[5];
    logic [3:0]  lk_gnt[5];
    logic [3:0]  lk_ack[5];
    logic [7:0]  lk_q[5];
    logic        lk_busy[5];

    initial begin
        // Fairness from ptr=0, then idle, then a lone write from requester 0.
        vecs[0]  = '{4'hF, 32'h13121110, 4'h1, 4'h0, 8'h00, 1'b1};
        vecs[1]  = '{4'hF, 32'h13121110, 4'h0, 4'h1, 8'h10, 1'b0};
        vecs[2]  = '{4'hF, 32'h13121110, 4'h2, 4'h0, 8'h10, 1'b1};
        vecs[3]  = '{4'hF, 32'h13121110, 4'h0, 4'h2, 8'h11, 1'b0};
        vecs[4]  = '{4'hF, 32'h13121110, 4'h4, 4'h0, 8'h11, 1'b1};
        vecs[5]  = '{4'hF, 32'h13121110, 4'h0, 4'h4, 8'h12, 1'b0};
        vecs[6]  = '{4'hF, 32'h13121110, 4'h8, 4'h0, 8'h12, 1'b1};
        vecs[7]  = '{4'hF, 32'h13121110, 4'h0, 4'h8, 8'h13, 1'b0};
        vecs[8]  = '{4'hF, 32'h13121110, 4'h1, 4'h0, 8'h13, 1'b1};
        vecs[9]  = '{4'hF, 32'h13121110, 4'h0, 4'h1, 8'h10, 1'b0};
        vecs[10] = '{4'h0, 32'h13121110, 4'h0, 4'h0, 8'h10, 1'b0};
        vecs[11] = '{4'h1, 32'h000000A5, 4'h1, 4'h0, 8'h10, 1'b1};
        vecs[12] = '{4'h1, 32'h000000A5, 4'h0, 4'h1, 8'hA5, 1'b0};
        vecs[13] = '{4'h0, 32'h000000A5, 4'h0, 4'h0, 8'hA5, 1'b0};

        lk_req  = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
        lk_lock = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
        lk_wd   = '{32'h00009911, 32'h00009911, 32'h00009922, 32'h00009933, 32'h00009933};
`ifdef SHARED_REG_ARB_LOCK_EN
        lk_gnt  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2};
        lk_ack  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
        lk_q    = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h33};
        lk_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        lk_gnt  = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h1};
        lk_ack  = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0};
        lk_q    = '{8'h00, 8'h11, 8'h11, 8'h99, 8'h99};
        lk_busy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

        reset     = 1'b1;
        bus.req   = 4'h0;
        bus.lock  = 4'h0;
        bus.wdata = 32'h0;
        model_reset();

        // Reset held with random traffic on the inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req   = 4'($urandom);
            bus.lock  = 4'($urandom);
            bus.wdata = $urandom;
            tick();
            check_outs($sformatf("rst%0d", i), 4'h0, 4'h0, 8'h00, 1'b0);
        end
        @(negedge clk);
        bus.req  = 4'h0;
        bus.lock = 4'h0;
        reset    = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].req, 4'h0, vecs[i].wdata);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack, vecs[i].q, vecs[i].busy);
        end

        // Reset asserted between edges while requester 2 holds the grant.
        drive(4'h4, 4'h0, 32'h005A0077);
        tick();
        check_outs("pre_rst", 4'h4, 4'h0, 8'hA5, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_outs("async_rst", 4'h0, 4'h0, 8'h00, 1'b0);
        tick();
        check_outs("rst_edge", 4'h0, 4'h0, 8'h00, 1'b0);
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 4'h5;
        tick();
        check_outs("post_rst_gnt", 4'h1, 4'h0, 8'h00, 1'b1);
        drive(4'h5, 4'h0, 32'h005A0077);
        tick();
        check_outs("post_rst_wr", 4'h0, 4'h1, 8'h77, 1'b0);

        // Withdrawal during GRANT: no write, no ack, rotation moves on.
        do_reset();
        drive(4'h3, 4'h0, 32'h0000BBAA);
        tick();
        check_outs("wd_gnt", 4'h1, 4'h0, 8'h00, 1'b1);
        drive(4'h2, 4'h0, 32'h0000BBAA);
        tick();
        check_outs("wd_drop", 4'h0, 4'h0, 8'h00, 1'b0);
        drive(4'h2, 4'h0, 32'h0000BBAA);
        tick();
        check_outs("wd_next", 4'h2, 4'h0, 8'h00, 1'b1);
        drive(4'h2, 4'h0, 32'h0000BBAA);
        tick();
        check_outs("wd_wr", 4'h0, 4'h2, 8'hBB, 1'b0);

        // Locked burst from requester 0 with requester 1 waiting.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(lk_req[i], lk_lock[i], lk_wd[i]);
            tick();
            check_outs($sformatf("lock%0d", i), lk_gnt[i], lk_ack[i], lk_q[i], lk_busy[i]);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            logic [3:0] l;
            r = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            l = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            drive(r, l, $urandom);
            @(posedge clk);
            model_edge();
            #1;
            model_compare();
        end
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
